iir_order2_seq: RTL and testbench

- Sequential control and state stage wrapped around the combinational second-order IIR core (biquad).
- Accepts a stream of samples tagged with a channel number, time-multiplexed over NCH channels.
- Holds per-channel x/y history and the active coefficient bank, and drives the core's x0/x1/x2/y1/y2 and coefficient inputs.
- Captures the core's y0 result, returns it on a valid/ready output stream, and advances that channel's history.

---
 rtl/iir_order2_seq.sv | 189 ++++++++++++++++++
 tb/tb_iir_order2_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/iir_order2_seq.sv
// Sequencing and state wrapper around a combinational biquad core: channel-multiplexed
// sample stream in, per-channel x/y history, shadow/active coefficient banks, result stream out.
module iir_order2_seq #(
    parameter int DWIDTH = 16,
    parameter int CWIDTH = 24,
    parameter int NCH    = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_coef_we,
    input  logic [2:0]                  i_coef_addr,
    input  logic signed [CWIDTH-1:0]    i_coef_wdata,
    input  logic                        i_coef_commit,
    input  logic                        i_hist_clr,
    input  logic                        i_in_valid,
    output logic                        o_in_ready,
    input  logic [$clog2(NCH)-1:0]      i_in_ch,
    input  logic signed [DWIDTH-1:0]    i_in_data,
    output logic                        o_out_valid,
    input  logic                        i_out_ready,
    output logic [$clog2(NCH)-1:0]      o_out_ch,
    output logic signed [DWIDTH-1:0]    o_out_data,
    output logic signed [DWIDTH-1:0]    o_core_x0,
    output logic signed [DWIDTH-1:0]    o_core_x1,
    output logic signed [DWIDTH-1:0]    o_core_x2,
    output logic signed [DWIDTH-1:0]    o_core_y1,
    output logic signed [DWIDTH-1:0]    o_core_y2,
    output logic signed [CWIDTH-1:0]    o_core_b0,
    output logic signed [CWIDTH-1:0]    o_core_b1,
    output logic signed [CWIDTH-1:0]    o_core_b2,
    output logic signed [CWIDTH-1:0]    o_core_a1,
    output logic signed [CWIDTH-1:0]    o_core_a2,
    input  logic signed [DWIDTH-1:0]    i_core_y0
);

    localparam int CHW = $clog2(NCH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_OUT} state_t;

    state_t r_state, w_state_nxt;

    logic w_accept, w_capture, w_release, w_do_commit, w_do_clr, w_in_ready;
    logic r_commit_pend, r_clr_pend, r_vld_p1;

    logic signed [DWIDTH-1:0] r_x0_p0;
    logic [CHW-1:0]           r_ch_p0;
    logic signed [DWIDTH-1:0] r_out_data_p1;
    logic [CHW-1:0]           r_out_ch_p1;
    logic signed [DWIDTH-1:0] r_cx0, r_cx1, r_cx2, r_cy1, r_cy2;

    logic signed [DWIDTH-1:0] r_hx1 [NCH];
    logic signed [DWIDTH-1:0] r_hx2 [NCH];
    logic signed [DWIDTH-1:0] r_hy1 [NCH];
    logic signed [DWIDTH-1:0] r_hy2 [NCH];

    logic signed [CWIDTH-1:0] r_sb0, r_sb1, r_sb2, r_sa1, r_sa2;
    logic signed [CWIDTH-1:0] r_ab0, r_ab1, r_ab2, r_aa1, r_aa2;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Pending commit/clear are serviced in IDLE, blocking intake for that one cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        w_do_commit = 1'b0;
        w_do_clr    = 1'b0;
        w_in_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_do_commit = r_commit_pend;
                w_do_clr    = r_clr_pend;
                w_in_ready  = !r_commit_pend && !r_clr_pend;
                if (i_in_valid && w_in_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                w_capture   = 1'b1;
                w_state_nxt = S_OUT;
            end
            S_OUT: begin
                if (i_out_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_commit_pend <= 1'b0;
            r_clr_pend    <= 1'b0;
            r_vld_p1      <= 1'b0;
        end else begin
            r_commit_pend <= i_coef_commit || (r_commit_pend && !w_do_commit);
            r_clr_pend    <= i_hist_clr || (r_clr_pend && !w_do_clr);
            if (w_capture)      r_vld_p1 <= 1'b1;
            else if (w_release) r_vld_p1 <= 1'b0;
        end
    end

    // Copy uses the pre-write shadow value when a write coincides with it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sb0 <= '0; r_sb1 <= '0; r_sb2 <= '0; r_sa1 <= '0; r_sa2 <= '0;
            r_ab0 <= '0; r_ab1 <= '0; r_ab2 <= '0; r_aa1 <= '0; r_aa2 <= '0;
        end else begin
            if (i_coef_we) begin
                case (i_coef_addr)
                    3'd0:    r_sb0 <= i_coef_wdata;
                    3'd1:    r_sb1 <= i_coef_wdata;
                    3'd2:    r_sb2 <= i_coef_wdata;
                    3'd3:    r_sa1 <= i_coef_wdata;
                    3'd4:    r_sa2 <= i_coef_wdata;
                    default: ;
                endcase
            end
            if (w_do_commit) begin
                r_ab0 <= r_sb0; r_ab1 <= r_sb1; r_ab2 <= r_sb2;
                r_aa1 <= r_sa1; r_aa2 <= r_sa2;
            end
        end
    end

    // Accept stage (p0): latch sample and present channel history to the core.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_x0_p0 <= '0;
            r_ch_p0 <= '0;
            r_cx0   <= '0; r_cx1 <= '0; r_cx2 <= '0; r_cy1 <= '0; r_cy2 <= '0;
        end else if (w_accept) begin
            r_x0_p0 <= i_in_data;
            r_ch_p0 <= i_in_ch;
            r_cx0   <= i_in_data;
            r_cx1   <= r_hx1[i_in_ch];
            r_cx2   <= r_hx2[i_in_ch];
            r_cy1   <= r_hy1[i_in_ch];
            r_cy2   <= r_hy2[i_in_ch];
        end
    end

    // Result stage (p1): capture core output and hold it until the handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_data_p1 <= '0;
            r_out_ch_p1   <= '0;
        end else if (w_capture) begin
            r_out_data_p1 <= i_core_y0;
            r_out_ch_p1   <= r_ch_p0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || w_do_clr) begin
            for (int i = 0; i < NCH; i++) begin
                r_hx1[i] <= '0; r_hx2[i] <= '0; r_hy1[i] <= '0; r_hy2[i] <= '0;
            end
        end else if (w_capture) begin
            r_hx2[r_ch_p0] <= r_hx1[r_ch_p0];
            r_hx1[r_ch_p0] <= r_x0_p0;
            r_hy2[r_ch_p0] <= r_hy1[r_ch_p0];
            r_hy1[r_ch_p0] <= i_core_y0;
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_vld_p1;
    assign o_out_ch    = r_out_ch_p1;
    assign o_out_data  = r_out_data_p1;
    assign o_core_x0   = r_cx0;
    assign o_core_x1   = r_cx1;
    assign o_core_x2   = r_cx2;
    assign o_core_y1   = r_cy1;
    assign o_core_y2   = r_cy2;
    assign o_core_b0   = r_ab0;
    assign o_core_b1   = r_ab1;
    assign o_core_b2   = r_ab2;
    assign o_core_a1   = r_aa1;
    assign o_core_a2   = r_aa2;

endmodule

// File: tb/tb_iir_order2_seq.sv
// Directed bench for iir_order2_seq with a behavioural biquad core attached.
module tb_iir_order2_seq;

    localparam int DW = 16;
    localparam int CW = 24;
    localparam int NCH = 4;

    logic clk, rst;
    logic coef_we, coef_commit, hist_clr;
    logic [2:0] coef_addr;
    logic signed [CW-1:0] coef_wdata;
    logic in_valid, in_ready, out_valid, out_ready;
    logic [1:0] in_ch, out_ch;
    logic signed [DW-1:0] in_data, out_data;
    logic signed [DW-1:0] cx0, cx1, cx2, cy1, cy2, cy0;
    logic signed [CW-1:0] cb0, cb1, cb2, ca1, ca2;

    int n_assert = 0;
    int n_fail   = 0;

    iir_order2_seq #(.DWIDTH(DW), .CWIDTH(CW), .NCH(NCH)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_coef_we(coef_we), .i_coef_addr(coef_addr), .i_coef_wdata(coef_wdata),
        .i_coef_commit(coef_commit), .i_hist_clr(hist_clr),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_ch(in_ch), .i_in_data(in_data),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_ch(out_ch), .o_out_data(out_data),
        .o_core_x0(cx0), .o_core_x1(cx1), .o_core_x2(cx2), .o_core_y1(cy1), .o_core_y2(cy2),
        .o_core_b0(cb0), .o_core_b1(cb1), .o_core_b2(cb2), .o_core_a1(ca1), .o_core_a2(ca2),
        .i_core_y0(cy0)
    );

    // Biquad core: y0 = (b0*x0 + b1*x1 + b2*x2 + a1*y1 + a2*y2) >> CW, truncated.
    function automatic logic signed [DW-1:0] core_model(
        input logic signed [DW-1:0] x0, x1, x2, y1, y2,
        input logic signed [CW-1:0] b0, b1, b2, a1, a2);
        logic signed [CW+DW+2:0] acc;
        acc = b0 * x0 + b1 * x1 + b2 * x2 + a1 * y1 + a2 * y2;
        return acc[CW+DW-1:CW];
    endfunction

    assign cy0 = core_model(cx0, cx1, cx2, cy1, cy2, cb0, cb1, cb2, ca1, ca2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_coef(input logic [2:0] a, input logic [CW-1:0] d);
        coef_we = 1'b1; coef_addr = a; coef_wdata = d;
        tick();
        coef_we = 1'b0;
    endtask

    task automatic pulse(input logic do_commit, input logic do_clr, input string tag);
        coef_commit = do_commit; hist_clr = do_clr;
        tick();
        coef_commit = 1'b0; hist_clr = 1'b0;
        chk({tag, "_busy"}, in_ready, 1'b0);
        tick();
        chk({tag, "_ready"}, in_ready, 1'b1);
    endtask

    // Presents one sample, checks the CALC cycle and the result; returns in OUT.
    task automatic send(input logic [1:0] ch, input logic [DW-1:0] d,
                        input logic [DW-1:0] exp, input string tag);
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin tick(); n++; end
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        in_valid = 1'b1; in_ch = ch; in_data = d;
        tick();
        in_valid = 1'b0;
        chk({tag, "_calc_vld"}, out_valid, 1'b0);
        chk({tag, "_core_x0"}, cx0, d);
        tick();
        chk({tag, "_vld"}, out_valid, 1'b1);
        chk({tag, "_data"}, out_data, exp);
        chk({tag, "_ch"}, out_ch, ch);
    endtask

    initial begin
        rst = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        coef_commit = 1'b0; hist_clr = 1'b0; in_valid = 1'b0; in_ch = '0;
        in_data = '0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_out_ch", out_ch, 2'd0);
        chk("rst_core_x0", cx0, 16'h0000);

        // b0 = 0.25
        write_coef(3'd0, 24'h400000);
        chk("shadow_only_b0", cb0, 24'h000000);
        pulse(1'b1, 1'b0, "commit1");
        chk("active_b0", cb0, 24'h400000);
        send(2'd0, 16'h1000, 16'h0400, "basic");

        // Recursion through y1 with a1 = 0.25
        write_coef(3'd3, 24'h400000);
        pulse(1'b0, 1'b1, "clr2");
        pulse(1'b1, 1'b0, "commit2");
        chk("active_a1", ca1, 24'h400000);
        send(2'd0, 16'h4000, 16'h1000, "rec0");
        send(2'd0, 16'h0000, 16'h0400, "rec1");
        send(2'd0, 16'h0000, 16'h0100, "rec2");

        // Channel isolation
        pulse(1'b0, 1'b1, "clr3");
        send(2'd0, 16'h4000, 16'h1000, "iso0");
        send(2'd1, 16'h0000, 16'h0000, "iso1");
        send(2'd0, 16'h0000, 16'h0400, "iso2");

        // Backpressure
        tick();
        out_ready = 1'b0;
        send(2'd2, 16'h4000, 16'h1000, "bp");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_vld", out_valid, 1'b1);
            chk("bp_hold_data", out_data, 16'h1000);
            chk("bp_hold_ch", out_ch, 2'd2);
            chk("bp_hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_vld", out_valid, 1'b0);
        chk("bp_release_in_ready", in_ready, 1'b1);

        // Commit while busy: b0 -> 0.125
        out_ready = 1'b0;
        send(2'd3, 16'h4000, 16'h1000, "cb_first");
        write_coef(3'd0, 24'h200000);
        coef_commit = 1'b1;
        tick();
        coef_commit = 1'b0;
        chk("cb_out_b0_unchanged", cb0, 24'h400000);
        chk("cb_out_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        tick();
        chk("cb_idle_vld", out_valid, 1'b0);
        chk("cb_idle_in_ready", in_ready, 1'b0);
        chk("cb_idle_b0_old", cb0, 24'h400000);
        tick();
        chk("cb_after_in_ready", in_ready, 1'b1);
        chk("cb_after_b0_new", cb0, 24'h200000);
        send(2'd3, 16'h4000, 16'h0C00, "cb_new");

        // hist_clr together with a commit, both issued while busy
        tick();
        out_ready = 1'b0;
        send(2'd3, 16'h4000, 16'h0B00, "clr_pre");
        write_coef(3'd0, 24'h400000);
        coef_commit = 1'b1; hist_clr = 1'b1;
        tick();
        coef_commit = 1'b0; hist_clr = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("cc_idle_in_ready", in_ready, 1'b0);
        tick();
        chk("cc_after_in_ready", in_ready, 1'b1);
        chk("cc_after_b0", cb0, 24'h400000);
        send(2'd3, 16'h4000, 16'h1000, "clr_fresh");

        // Reset during CALC
        send(2'd0, 16'h4000, 16'h1000, "pre_rst");
        tick();
        in_valid = 1'b1; in_ch = 2'd0; in_data = 16'h4000;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid_rst_vld", out_valid, 1'b0);
        chk("mid_rst_data", out_data, 16'h0000);
        chk("mid_rst_b0", cb0, 24'h000000);
        chk("mid_rst_core_x0", cx0, 16'h0000);
        rst = 1'b0;
        tick();
        chk("post_rst_vld", out_valid, 1'b0);
        write_coef(3'd0, 24'h400000);
        write_coef(3'd3, 24'h400000);
        pulse(1'b1, 1'b0, "commit_rst");
        send(2'd0, 16'h4000, 16'h1000, "post_rst");
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
